// File: rtl/button_conditioner.sv
// Button front end: 2-flop sync, per-channel debounce, single-cycle active-low
// press pulses, and hold-to-repeat on the increment/decrement channels.

module bc_debounce #(
    parameter int D = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic press_o,
    output logic release_o,
    output logic pressed_o
);
    localparam int CW = $clog2(D + 1);

    logic [1:0]    sync_q, sync_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s, flip;

    assign s = sync_q[1];

    always_comb begin
        sync_d   = {sync_q[0], raw_n};
        stable_d = stable_q;
        cnt_d    = '0;
        flip     = 1'b0;
        if (s != stable_q) begin
            if (cnt_q == CW'(D - 1)) begin
                flip     = 1'b1;
                stable_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Flip strobes are combinational so the top can register the pulse on the flip edge.
    assign press_o   = flip & ~s;
    assign release_o = flip & s;
    assign pressed_o = ~stable_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module bc_repeat #(
    parameter int H = 6,
    parameter int R = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic press_i,
    input  logic release_i,
    input  logic hold_i,
    output logic rpt_o
);
    localparam int MAXC = (H > R) ? H : R;
    localparam int RW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = (cnt_q == {RW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_o   = 1'b0;
        if (release_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (press_i) begin
            state_d = WAIT_HOLD;
            cnt_d   = '0;
        end else if (!hold_i) begin
            case (state_q)
                WAIT_HOLD: begin
                    if (cnt_q >= RW'(H - 1)) begin
                        rpt_o   = 1'b1;
                        state_d = REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                REPEAT: begin
                    if (cnt_q >= RW'(R - 1)) begin
                        rpt_o = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 6,
    parameter int REPEAT_CYCLES   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_inc_n,
    input  logic btn_dec_n,
    input  logic btn_chg_n,
    input  logic btn_set_n,
    output logic incrementar,
    output logic decrementar,
    output logic cambiar,
    output logic establecer
);
    logic [3:0] btn_n, press, rel, pressed, pulse;
    logic [1:0] rpt;
    logic [3:0] out_q, out_d;
    logic       conflict;

    assign btn_n = {btn_set_n, btn_chg_n, btn_dec_n, btn_inc_n};

    bc_debounce #(.D(DEBOUNCE_CYCLES)) u_db [3:0] (
        .clk      (clk),
        .reset    (reset),
        .raw_n    (btn_n),
        .press_o  (press),
        .release_o(rel),
        .pressed_o(pressed)
    );

    assign conflict = pressed[0] & pressed[1];

    bc_repeat #(.H(HOLD_CYCLES), .R(REPEAT_CYCLES)) u_rpt [1:0] (
        .clk      (clk),
        .reset    (reset),
        .press_i  (press[1:0]),
        .release_i(rel[1:0]),
        .hold_i   (conflict),
        .rpt_o    (rpt)
    );

    assign pulse = press | {2'b00, rpt};

    // A pulse right after another is dropped so each low is followed by a high.
    always_comb begin
        out_d = ~(pulse & out_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_q <= 4'hF;
        else        out_q <= out_d;
    end

    assign incrementar = out_q[0];
    assign decrementar = out_q[1];
    assign cambiar     = out_q[2];
    assign establecer  = out_q[3];
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed edge tables, async-reset sequences and
// randomized bouncing buttons checked against a timing-rule reference model.

module tb_button_conditioner;
    localparam int D = 4, H = 6, R = 2;
    localparam int NRAND = 2000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] btn_n = 4'hF;
    logic incrementar, decrementar, cambiar, establecer;
    logic [3:0] outv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_inc_n  (btn_n[0]),
        .btn_dec_n  (btn_n[1]),
        .btn_chg_n  (btn_n[2]),
        .btn_set_n  (btn_n[3]),
        .incrementar(incrementar),
        .decrementar(decrementar),
        .cambiar    (cambiar),
        .establecer (establecer)
    );

    assign outv = {establecer, cambiar, decrementar, incrementar};

    typedef struct {
        string       name;
        logic [3:0]  mask;      // buttons held low during [lo_s, lo_e]
        int          lo_s;
        int          lo_e;
        int          rst_s;     // reset low for edges in [rst_s, rst_e)
        int          rst_e;
        logic [3:0]  exp_mask;  // outputs that pulse at the listed edges
        logic [63:0] exp_edges;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int e, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: outputs(set,chg,dec,inc)=%b expected %b", name, e, act, exp);
        end
    endtask

    // Leaves the bench at a falling edge with reset released and buttons up.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        btn_n = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [63:0] eb(input int e);
        logic [63:0] one;
        one = 64'd1;
        return one << e;
    endfunction

    // Reference model state for the random run: channel 0=inc, 1=chg, 2=set.
    logic hist[3][NRAND];
    logic mstable[3];
    int   mpress[3];

    function automatic logic raw_at(input int c, input int i);
        if (i < 0) return 1'b1;
        return hist[c][i];
    endfunction

    initial begin
        logic [3:0] exp;
        logic [3:0] lvl;
        int run[3];
        bit got;

        vecs[0] = '{"bounce", 4'b0001, 10, 12, -1, -1, 4'b0001, 64'd0};
        vecs[1] = '{"single_chg", 4'b0100, 10, 29, -1, -1, 4'b0100, eb(15)};
        vecs[2] = '{"single_set", 4'b1000, 10, 29, -1, -1, 4'b1000, eb(15)};
        vecs[3] = '{"chg_set_together", 4'b1100, 10, 29, -1, -1, 4'b1100, eb(15)};
        vecs[4] = '{"auto_repeat", 4'b0001, 10, 29, -1, -1, 4'b0001,
                    eb(15) | eb(21) | eb(23) | eb(25) | eb(27) | eb(29) | eb(31) | eb(33)};
        vecs[5] = '{"conflict", 4'b0011, 10, 40, -1, -1, 4'b0011, eb(15)};
        vecs[6] = '{"reset_mid_repeat", 4'b0001, 10, 51, 24, 30, 4'b0001,
                    eb(15) | eb(21) | eb(23) | eb(35) | eb(41) | eb(43) | eb(45) | eb(47) | eb(49) | eb(51)};

        // Reset held while buttons toggle: every output stays high.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn_n = 4'($urandom);
            @(posedge clk);
            #1 chk("reset_hold", i, outv, 4'hF);
        end

        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int e = 0; e < 52; e++) begin
                btn_n = 4'hF;
                if (e >= vecs[v].lo_s && e <= vecs[v].lo_e) btn_n = btn_n & ~vecs[v].mask;
                reset = !(e >= vecs[v].rst_s && e < vecs[v].rst_e);
                @(posedge clk);
                #1;
                exp = 4'hF;
                if (vecs[v].exp_edges[e]) exp = exp & ~vecs[v].exp_mask;
                chk(vecs[v].name, e, outv, exp);
                @(negedge clk);
            end
        end

        // An asserted reset forces a live pulse high without waiting for a clock.
        do_reset();
        btn_n = 4'b1110;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            #1 if (incrementar === 1'b0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL async_reset_setup: incrementar never pulsed within 30 cycles, required a pulse");
        end
        reset = 1'b0;
        #1 chk("async_reset_immediate", 0, outv, 4'hF);
        btn_n = 4'hF;

        // Randomized bouncing on inc/chg/set; dec stays released so inc repeats freely.
        do_reset();
        lvl = 4'hF;
        for (int c = 0; c < 3; c++) begin
            run[c] = 0;
            mstable[c] = 1'b1;
            mpress[c] = 0;
        end
        for (int e = 0; e < NRAND; e++) begin
            for (int c = 0; c < 3; c++) begin
                if (run[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    run[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40))
                                                         : int'($urandom_range(1, 6));
                end
                run[c]--;
                hist[c][e] = lvl[c];
            end
            btn_n = {lvl[2], lvl[1], 1'b1, lvl[0]};
            @(posedge clk);
            #1;
            exp = 4'hF;
            for (int c = 0; c < 3; c++) begin
                bit flip, pls;
                flip = 1'b1;
                for (int j = 2; j <= D + 1; j++)
                    if (raw_at(c, e - j) == mstable[c]) flip = 1'b0;
                pls = 1'b0;
                if (flip) begin
                    mstable[c] = ~mstable[c];
                    if (mstable[c] == 1'b0) begin
                        pls = 1'b1;
                        mpress[c] = e;
                    end
                end else if (c == 0 && mstable[c] == 1'b0 && (e - mpress[c]) >= H
                             && ((e - mpress[c] - H) % R) == 0) begin
                    pls = 1'b1;
                end
                if (pls) begin
                    case (c)
                        0:       exp[0] = 1'b0;
                        1:       exp[2] = 1'b0;
                        default: exp[3] = 1'b0;
                    endcase
                end
            end
            chk("random", e, outv, exp);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
